// File: rtl/uart_receiver_if.sv
// Receive-side byte handshake between uart_receiver and its consumer.
// Carries the received byte, its status flags and the consumer acknowledge.
interface uart_receiver_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       rx_ack;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output overrun_err,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  overrun_err,
        output rx_ack
    );
endinterface

// File: rtl/uart_receiver.sv
// UART serial receive stage: 16x oversampled deserialiser with framing, parity
// and overrun status, delivering each byte over a valid/ack handshake.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       os_tick,
    input  logic       rxd,
    output logic       busy,
    output logic [2:0] dbg_state,
    uart_receiver_if.master rx
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    localparam int         MSB       = DATA_BITS - 1;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);

    state_t     state_q;
    logic       sync1_q;
    logic       rx_s_q;
    logic [3:0] tick_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       par_pend_q;
    logic       stop_bit_q;
    logic       load_q;
    logic       busy_q;

    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       frame_err_q;
    logic       parity_err_q;
    logic       overrun_err_q;

    logic [7:0] shift_d;
    logic       parity_err_d;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rx_s_q  <= sync1_q;
        end
    end

    // New bit enters at the top of the active field so the first bit ends in bit 0.
    always_comb begin
        shift_d      = (shift_q >> 1) & DATA_MASK;
        shift_d[MSB] = rx_s_q;
        parity_err_d = (^shift_q) ^ rx_s_q ^ PARITY_ODD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_pend_q <= 1'b0;
            stop_bit_q <= 1'b1;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (os_tick && !rx_s_q) begin
                        tick_cnt_q <= 4'd0;
                        state_q    <= S_START;
                        busy_q     <= 1'b1;
                    end
                end
                S_START: begin
                    if (os_tick) begin
                        if (tick_cnt_q == 4'd7) begin
                            tick_cnt_q <= 4'd0;
                            if (!rx_s_q) begin
                                bit_cnt_q  <= 3'd0;
                                par_pend_q <= 1'b0;
                                state_q    <= S_DATA;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (os_tick) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= PARITY_EN ? S_PARITY : S_STOP;
                            end
                        end
                    end
                end
                S_PARITY: begin
                    if (os_tick) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            par_pend_q <= parity_err_d;
                            state_q    <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (os_tick) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            load_q     <= 1'b1;
                            stop_bit_q <= rx_s_q;
                            if (rx_s_q) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_BRK_WAIT;
                            end
                        end
                    end
                end
                S_BRK_WAIT: begin
                    // A held-low line is one break, not a stream of zero bytes.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Handshake: rx_valid with data and flags holds until a clk where rx_ack=1
    // and rx_valid=1; a load in that same cycle wins and is not an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else if (load_q) begin
            rx_data_q     <= shift_q;
            rx_valid_q    <= 1'b1;
            frame_err_q   <= ~stop_bit_q;
            parity_err_q  <= par_pend_q;
            overrun_err_q <= rx_valid_q & ~rx.rx_ack;
        end else if (rx_valid_q && rx.rx_ack) begin
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end
    end

    assign rx.rx_data     = rx_data_q;
    assign rx.rx_valid    = rx_valid_q;
    assign rx.frame_err   = frame_err_q;
    assign rx.parity_err  = parity_err_q;
    assign rx.overrun_err = overrun_err_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized bench for uart_receiver: three instances cover 8N1,
// 8-bit odd parity and 7-bit odd parity, each with its own serial line.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       os_tick;
    logic       rxd_a [3];
    logic       ack_a [3];
    logic [7:0] data_a [3];
    logic       valid_a [3];
    logic       ferr_a [3];
    logic       perr_a [3];
    logic       oerr_a [3];
    logic       busy_a [3];
    logic [2:0] st_a [3];

    int tick_period = 16;
    int tick_div    = 0;
    int checks      = 0;
    int errors      = 0;

    uart_receiver_if bus0 ();
    uart_receiver_if bus1 ();
    uart_receiver_if bus2 ();

    assign bus0.rx_ack = ack_a[0];
    assign bus1.rx_ack = ack_a[1];
    assign bus2.rx_ack = ack_a[2];
    assign data_a[0] = bus0.rx_data;  assign data_a[1] = bus1.rx_data;  assign data_a[2] = bus2.rx_data;
    assign valid_a[0] = bus0.rx_valid; assign valid_a[1] = bus1.rx_valid; assign valid_a[2] = bus2.rx_valid;
    assign ferr_a[0] = bus0.frame_err; assign ferr_a[1] = bus1.frame_err; assign ferr_a[2] = bus2.frame_err;
    assign perr_a[0] = bus0.parity_err; assign perr_a[1] = bus1.parity_err; assign perr_a[2] = bus2.parity_err;
    assign oerr_a[0] = bus0.overrun_err; assign oerr_a[1] = bus1.overrun_err; assign oerr_a[2] = bus2.overrun_err;

    uart_receiver #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
        .clk(clk), .reset(reset), .os_tick(os_tick), .rxd(rxd_a[0]),
        .busy(busy_a[0]), .dbg_state(st_a[0]), .rx(bus0));
    uart_receiver #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (
        .clk(clk), .reset(reset), .os_tick(os_tick), .rxd(rxd_a[1]),
        .busy(busy_a[1]), .dbg_state(st_a[1]), .rx(bus1));
    uart_receiver #(.DATA_BITS(7), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (
        .clk(clk), .reset(reset), .os_tick(os_tick), .rxd(rxd_a[2]),
        .busy(busy_a[2]), .dbg_state(st_a[2]), .rx(bus2));

    // Clock and oversampling strobe
    always #5 clk = ~clk;

    initial begin
        os_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_div >= tick_period - 1) begin
                tick_div = 0;
                os_tick  = 1'b1;
            end else begin
                tick_div++;
                os_tick = 1'b0;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference model: parity error from the frame contents by plain arithmetic
    function automatic logic exp_perr(input logic [7:0] d, input logic pbit, input bit odd);
        int s;
        s = $countones(d) + int'(pbit);
        return ((s + int'(odd)) % 2) == 1;
    endfunction

    function automatic logic good_pbit(input logic [7:0] d, input bit odd);
        return 1'(($countones(d) + int'(odd)) % 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align_tick();
        do @(posedge clk); while (!os_tick);
        @(negedge clk);
    endtask

    task automatic send_bit(input int idx, input logic b);
        rxd_a[idx] = b;
        repeat (16 * tick_period) @(negedge clk);
    endtask

    task automatic send_frame(input int idx, input logic [7:0] d, input int nbits,
                              input bit par_en, input logic pbit, input logic stop);
        send_bit(idx, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(idx, d[i]);
        if (par_en) send_bit(idx, pbit);
        send_bit(idx, stop);
    endtask

    task automatic wait_valid(input string tag, input int idx);
        int n;
        n = 0;
        while (!valid_a[idx] && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_valid", tag), 32'(valid_a[idx]), 32'd1);
    endtask

    task automatic expect_byte(input string tag, input int idx, input logic [7:0] d,
                               input logic fe, input logic pe, input logic oe);
        wait_valid(tag, idx);
        chk($sformatf("%s_data", tag), 32'(data_a[idx]), 32'(d));
        chk($sformatf("%s_frame_err", tag), 32'(ferr_a[idx]), 32'(fe));
        chk($sformatf("%s_parity_err", tag), 32'(perr_a[idx]), 32'(pe));
        chk($sformatf("%s_overrun_err", tag), 32'(oerr_a[idx]), 32'(oe));
    endtask

    task automatic do_ack(input string tag, input int idx);
        ack_a[idx] = 1'b1;
        @(negedge clk);
        ack_a[idx] = 1'b0;
        chk($sformatf("%s_ack_valid", tag), 32'(valid_a[idx]), 32'd0);
        chk($sformatf("%s_ack_flags", tag),
            32'({ferr_a[idx], perr_a[idx], oerr_a[idx]}), 32'd0);
    endtask

    bit pend [3];

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rxd_a[i] = 1'b1;
            ack_a[i] = 1'b0;
            pend[i]  = 1'b0;
        end
        #3 reset = 1'b0;
        wait_clks(3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_valid%0d", i), 32'(valid_a[i]), 32'd0);
            chk($sformatf("reset_data%0d", i), 32'(data_a[i]), 32'd0);
            chk($sformatf("reset_busy%0d", i), 32'(busy_a[i]), 32'd0);
            chk($sformatf("reset_flags%0d", i), 32'({ferr_a[i], perr_a[i], oerr_a[i]}), 32'd0);
        end
        reset = 1'b1;
        wait_clks(40);

        // Normal 8N1 byte
        align_tick();
        send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
        expect_byte("normal", 0, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("normal_busy", 32'(busy_a[0]), 32'd0);
        do_ack("normal", 0);

        // Glitch: low for 3 ticks only
        align_tick();
        rxd_a[0] = 1'b0;
        wait_clks(20);
        chk("glitch_busy_rise", 32'(busy_a[0]), 32'd1);
        wait_clks(28);
        rxd_a[0] = 1'b1;
        wait_clks(100);
        chk("glitch_busy_fall", 32'(busy_a[0]), 32'd0);
        chk("glitch_no_valid", 32'(valid_a[0]), 32'd0);
        align_tick();
        send_frame(0, 8'h5A, 8, 1'b0, 1'b0, 1'b1);
        expect_byte("after_glitch", 0, 8'h5A, 1'b0, 1'b0, 1'b0);
        do_ack("after_glitch", 0);

        // Framing error then break
        align_tick();
        send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b0);
        expect_byte("frame_err", 0, 8'h3C, 1'b1, 1'b0, 1'b0);
        do_ack("frame_err", 0);
        wait_clks(40 * 16 * 16);
        chk("break_no_valid", 32'(valid_a[0]), 32'd0);
        chk("break_busy", 32'(busy_a[0]), 32'd1);
        rxd_a[0] = 1'b1;
        wait_clks(256);
        chk("break_release_busy", 32'(busy_a[0]), 32'd0);
        align_tick();
        send_frame(0, 8'h01, 8, 1'b0, 1'b0, 1'b1);
        expect_byte("after_break", 0, 8'h01, 1'b0, 1'b0, 1'b0);
        do_ack("after_break", 0);

        // Overrun without ack
        align_tick();
        send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1'b1);
        align_tick();
        send_frame(0, 8'h22, 8, 1'b0, 1'b0, 1'b1);
        expect_byte("overrun", 0, 8'h22, 1'b0, 1'b0, 1'b1);
        do_ack("overrun", 0);

        // Ack lands on the load edge of the second byte: stop sample is the
        // 153rd tick from the start edge (detection + 8 + 16*9).
        align_tick();
        send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1'b1);
        wait_valid("ov_coincide_first", 0);
        align_tick();
        fork
            send_frame(0, 8'h22, 8, 1'b0, 1'b0, 1'b1);
            begin
                repeat (153) begin
                    do @(posedge clk); while (!os_tick);
                end
                @(negedge clk);
                ack_a[0] = 1'b1;
                @(negedge clk);
                ack_a[0] = 1'b0;
            end
        join
        chk("ov_coincide_valid", 32'(valid_a[0]), 32'd1);
        chk("ov_coincide_data", 32'(data_a[0]), 32'h22);
        chk("ov_coincide_overrun", 32'(oerr_a[0]), 32'd0);
        do_ack("ov_coincide", 0);

        // Odd parity, 8 and 7 data bits
        align_tick();
        send_frame(1, 8'h07, 8, 1'b1, 1'b0, 1'b1);
        expect_byte("par_good", 1, 8'h07, 1'b0, 1'b0, 1'b0);
        do_ack("par_good", 1);
        align_tick();
        send_frame(1, 8'h07, 8, 1'b1, 1'b1, 1'b1);
        expect_byte("par_bad", 1, 8'h07, 1'b0, 1'b1, 1'b0);
        do_ack("par_bad", 1);
        align_tick();
        send_frame(2, 8'h7F, 7, 1'b1, good_pbit(8'h7F, 1'b1), 1'b1);
        expect_byte("par_7bit", 2, 8'h7F, 1'b0, 1'b0, 1'b0);
        do_ack("par_7bit", 2);

        // Reset during data bit 4 of 0xFF, with an unacked byte held
        align_tick();
        send_frame(0, 8'h96, 8, 1'b0, 1'b0, 1'b1);
        wait_valid("pre_reset", 0);
        align_tick();
        fork
            send_frame(0, 8'hFF, 8, 1'b0, 1'b0, 1'b1);
            begin
                wait_clks(5 * 256 + 128);
                chk("mid_frame_busy", 32'(busy_a[0]), 32'd1);
                #2 reset = 1'b0;
                #1;
                chk("async_reset_valid", 32'(valid_a[0]), 32'd0);
                chk("async_reset_data", 32'(data_a[0]), 32'd0);
                chk("async_reset_busy", 32'(busy_a[0]), 32'd0);
                chk("async_reset_flags", 32'({ferr_a[0], perr_a[0], oerr_a[0]}), 32'd0);
                wait_clks(20);
                reset = 1'b1;
            end
        join
        chk("abandoned_no_valid", 32'(valid_a[0]), 32'd0);
        wait_clks(2 * 256);
        align_tick();
        send_frame(0, 8'hC3, 8, 1'b0, 1'b0, 1'b1);
        expect_byte("after_reset", 0, 8'hC3, 1'b0, 1'b0, 1'b0);
        do_ack("after_reset", 0);

        // Randomized frames at a faster tick rate against the model
        tick_period = 2;
        wait_clks(40);
        for (int it = 0; it < 12; it++) begin
            int         idx;
            int         nb;
            bit         pe;
            logic [7:0] d;
            logic       pb;
            logic       st;
            bit         skip;
            idx  = $urandom_range(0, 2);
            nb   = (idx == 2) ? 7 : 8;
            pe   = (idx != 0);
            d    = 8'($urandom) & ((idx == 2) ? 8'h7F : 8'hFF);
            pb   = 1'($urandom);
            st   = ($urandom_range(0, 3) != 0);
            skip = ($urandom_range(0, 3) == 0);
            align_tick();
            send_frame(idx, d, nb, pe, pb, st);
            expect_byte($sformatf("rand%0d", it), idx, d, ~st,
                        pe ? exp_perr(d, pb, 1'b1) : 1'b0, pend[idx]);
            if (!st) begin
                rxd_a[idx] = 1'b1;
                wait_clks(16 * tick_period);
            end
            if (skip) begin
                pend[idx] = 1'b1;
            end else begin
                do_ack($sformatf("rand%0d", it), idx);
                pend[idx] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
